// File: rtl/prio_enc_pkg.sv
// Shared definitions for the registered interrupt priority encoder.
package prio_enc_pkg;

    // Upper bound on the number of request lines the encoder supports.
    localparam int MAX_N = 64;

    // Request capture mode, decoded from the EDGE_MODE parameter.
    typedef enum logic {
        MODE_LEVEL = 1'b0,
        MODE_EDGE  = 1'b1
    } mode_e;

    // Index width for n lines; never returns less than 1 so a 2-line
    // encoder still gets a usable 1-bit index.
    function automatic int clog2_safe(input int n);
        int result;
        result = 1;
        for (int w = 1; w < 7; w++) begin
            if ((1 << w) < n) result = w + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/prio_find.sv
// Combinational highest-set-bit finder: any = OR of vec, idx = position of
// the most significant set bit (0 when vec is empty).
module prio_find
    import prio_enc_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = clog2_safe(N)
) (
    input  logic [N-1:0]     vec,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    // Ascending scan: a later (higher) set bit overrides an earlier one.
    // NOTE: idx gets a default before the loop so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        any = |vec;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/prio_encoder_irq.sv
// Registered N-line priority encoder with per-line mask, optional rising-edge
// latching into a pending register, and a valid/ready output handshake.
// Line N-1 has the highest priority. A presented index is never retracted or
// preempted while the consumer stalls.
module prio_encoder_irq
    import prio_enc_pkg::*;
#(
    parameter int N         = 8,
    parameter int IDX_W     = clog2_safe(N),
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [N-1:0]     pending
);

    localparam mode_e MODE = EDGE_MODE ? MODE_EDGE : MODE_LEVEL;

    // Elaboration-time guard on the parameter range.
    generate
        if (N < 2 || N > MAX_N) begin : g_bad_n
            $error("prio_encoder_irq: N out of range");
        end
        if (IDX_W < clog2_safe(N)) begin : g_bad_w
            $error("prio_encoder_irq: IDX_W too narrow for N");
        end
    endgenerate

    logic [N-1:0]     req_q;
    logic [N-1:0]     rise;
    logic [N-1:0]     ack_vec;
    logic [N-1:0]     pending_next;
    logic [N-1:0]     sel_base;
    logic [N-1:0]     cand;
    logic             ack;
    logic             upd;
    logic             cand_any;
    logic [IDX_W-1:0] cand_idx;

    // Handshake: a transfer happens when a valid index meets a ready consumer;
    // the output register may reload when it is empty or being drained.
    always_comb begin
        ack = out_valid & out_ready;
        upd = ~out_valid | out_ready;
    end

    // One-hot mask of the line being acknowledged this cycle.
    always_comb begin
        ack_vec = '0;
        for (int i = 0; i < N; i++) begin
            ack_vec[i] = ack && (out_idx == IDX_W'(i));
        end
    end

    // Next pending value and the base the selector looks at. In edge mode a
    // fresh rise on the acknowledged line wins over the clear; new rises only
    // join the selection one edge after they are latched. In level mode
    // pending mirrors req and acknowledges are ignored.
    always_comb begin
        rise = req & ~req_q;
        if (MODE == MODE_EDGE) begin
            pending_next = (pending & ~ack_vec) | rise;
            sel_base     = pending & ~ack_vec;
        end else begin
            pending_next = req;
            sel_base     = pending;
        end
        cand = sel_base & mask;
    end

    prio_find #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_find (
        .vec (cand),
        .any (cand_any),
        .idx (cand_idx)
    );

    // State: request history, pending lines and the presented selection,
    // which is frozen while the consumer stalls.
    // NOTE: registered state is written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            pending   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
        end else begin
            req_q   <= req;
            pending <= pending_next;
            if (upd) begin
                out_valid <= cand_any;
                out_idx   <= cand_any ? cand_idx : '0;
            end
        end
    end

endmodule

// File: tb/tb_prio_encoder_irq.sv
// Self-checking bench: an 8-line edge-mode encoder, an 8-line level-mode
// encoder and a 5-line edge-mode encoder, driven from vector tables with a
// scoreboard queue holding the expected post-edge outputs.
module tb_prio_encoder_irq;

    logic clk;
    logic rst_n;

    logic [7:0] req_e, mask_e, pend_e;
    logic       rdy_e, ov_e;
    logic [2:0] oi_e;

    logic [7:0] req_l, mask_l, pend_l;
    logic       rdy_l, ov_l;
    logic [2:0] oi_l;

    logic [4:0] req_5, mask_5, pend_5;
    logic       rdy_5, ov_5;
    logic [2:0] oi_5;

    prio_encoder_irq #(.N(8), .EDGE_MODE(1'b1)) dut_e (
        .clk(clk), .rst_n(rst_n), .req(req_e), .mask(mask_e), .out_ready(rdy_e),
        .out_valid(ov_e), .out_idx(oi_e), .pending(pend_e)
    );

    prio_encoder_irq #(.N(8), .EDGE_MODE(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .req(req_l), .mask(mask_l), .out_ready(rdy_l),
        .out_valid(ov_l), .out_idx(oi_l), .pending(pend_l)
    );

    prio_encoder_irq #(.N(5), .EDGE_MODE(1'b1)) dut_5 (
        .clk(clk), .rst_n(rst_n), .req(req_5), .mask(mask_5), .out_ready(rdy_5),
        .out_valid(ov_5), .out_idx(oi_5), .pending(pend_5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic [7:0] mask;
        logic       rdy;
        logic       ev;
        logic [2:0] ei;
        logic [7:0] ep;
    } vec_t;

    typedef struct {
        int         unit;
        int         tag;
        logic       ev;
        logic [2:0] ei;
        logic [7:0] ep;
    } exp_t;

    exp_t sb[$];
    vec_t vt_e[$];
    vec_t vt_l[$];
    vec_t vt_5[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare it against the unit it names.
    task automatic compare_head();
        exp_t       e;
        logic       av;
        logic [2:0] ai;
        logic [7:0] ap;
        string      un;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        case (e.unit)
            0:       begin av = ov_e; ai = oi_e; ap = pend_e;        un = "edge8";  end
            1:       begin av = ov_l; ai = oi_l; ap = pend_l;        un = "level8"; end
            default: begin av = ov_5; ai = oi_5; ap = {3'b0, pend_5}; un = "edge5";  end
        endcase
        check($sformatf("%s#%0d out_valid", un, e.tag), 64'(av), 64'(e.ev));
        check($sformatf("%s#%0d out_idx",   un, e.tag), 64'(ai), 64'(e.ei));
        check($sformatf("%s#%0d pending",   un, e.tag), 64'(ap), 64'(e.ep));
    endtask

    // Drive one vector on a unit at the falling edge, record the expected
    // result, then compare just after the next rising edge.
    task automatic drive_cycle(input int unit, input int tag, input vec_t v);
        exp_t e;
        @(negedge clk);
        case (unit)
            0:       begin req_e = v.req;      mask_e = v.mask;      rdy_e = v.rdy; end
            1:       begin req_l = v.req;      mask_l = v.mask;      rdy_l = v.rdy; end
            default: begin req_5 = v.req[4:0]; mask_5 = v.mask[4:0]; rdy_5 = v.rdy; end
        endcase
        e.unit = unit; e.tag = tag; e.ev = v.ev; e.ei = v.ei; e.ep = v.ep;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_head();
    endtask

    function automatic vec_t mk(input logic [7:0] r, input logic [7:0] m, input logic rd,
                                input logic ev, input logic [2:0] ei, input logic [7:0] ep);
        vec_t v;
        v.req = r; v.mask = m; v.rdy = rd; v.ev = ev; v.ei = ei; v.ep = ep;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Edge-mode vectors: {req, mask, ready} -> {valid, idx, pending} after the edge.
        vt_e.push_back(mk(8'h28, 8'hFF, 0, 0, 0, 8'h28));  // 3 and 5 rise together
        vt_e.push_back(mk(8'h28, 8'hFF, 0, 1, 5, 8'h28));
        vt_e.push_back(mk(8'h28, 8'hFF, 0, 1, 5, 8'h28));  // held while stalled
        vt_e.push_back(mk(8'h28, 8'hFF, 0, 1, 5, 8'h28));
        vt_e.push_back(mk(8'h28, 8'hFF, 0, 1, 5, 8'h28));
        vt_e.push_back(mk(8'h28, 8'hFF, 0, 1, 5, 8'h28));
        vt_e.push_back(mk(8'h28, 8'hFF, 1, 1, 3, 8'h08));  // ack 5 -> 3 with no bubble
        vt_e.push_back(mk(8'h28, 8'hFF, 0, 1, 3, 8'h08));
        vt_e.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 8'h00));  // ack 3 -> empty
        vt_e.push_back(mk(8'h00, 8'hFF, 0, 0, 0, 8'h00));
        vt_e.push_back(mk(8'h28, 8'hFF, 0, 0, 0, 8'h28));  // 3 and 5 rise again
        vt_e.push_back(mk(8'h28, 8'hFF, 0, 1, 5, 8'h28));
        vt_e.push_back(mk(8'hA8, 8'hFF, 0, 1, 5, 8'hA8));  // 7 rises, no preemption
        vt_e.push_back(mk(8'hA8, 8'hDF, 0, 1, 5, 8'hA8));  // presented line masked, still held
        vt_e.push_back(mk(8'hA8, 8'hFF, 1, 1, 7, 8'h88));
        vt_e.push_back(mk(8'hA8, 8'hFF, 1, 1, 3, 8'h08));
        vt_e.push_back(mk(8'hA8, 8'hFF, 1, 0, 0, 8'h00));
        vt_e.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 8'h00));
        vt_e.push_back(mk(8'h20, 8'hDF, 0, 0, 0, 8'h20));  // masked line still latched
        vt_e.push_back(mk(8'h20, 8'hDF, 0, 0, 0, 8'h20));
        vt_e.push_back(mk(8'h20, 8'hDF, 0, 0, 0, 8'h20));
        vt_e.push_back(mk(8'h20, 8'hFF, 0, 1, 5, 8'h20));  // unmask -> presented next edge
        vt_e.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 8'h00));
        vt_e.push_back(mk(8'h04, 8'hFF, 0, 0, 0, 8'h04));
        vt_e.push_back(mk(8'h04, 8'hFF, 0, 1, 2, 8'h04));
        vt_e.push_back(mk(8'h00, 8'hFF, 0, 1, 2, 8'h04));
        vt_e.push_back(mk(8'h04, 8'hFF, 1, 0, 0, 8'h04));  // ack 2 with re-rise: set wins
        vt_e.push_back(mk(8'h04, 8'hFF, 1, 1, 2, 8'h04));  // re-presented
        vt_e.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 8'h00));

        // Level-mode vectors, consumer always ready.
        vt_l.push_back(mk(8'h11, 8'hFF, 1, 0, 0, 8'h11));
        vt_l.push_back(mk(8'h11, 8'hFF, 1, 1, 4, 8'h11));
        vt_l.push_back(mk(8'h11, 8'hFF, 1, 1, 4, 8'h11));  // ack does not clear level pending
        vt_l.push_back(mk(8'h11, 8'hFF, 1, 1, 4, 8'h11));
        vt_l.push_back(mk(8'h01, 8'hFF, 1, 1, 4, 8'h01));  // drop req[4]
        vt_l.push_back(mk(8'h01, 8'hFF, 1, 1, 0, 8'h01));  // idx 0 two edges later
        vt_l.push_back(mk(8'h11, 8'hFF, 1, 1, 0, 8'h11));
        vt_l.push_back(mk(8'h11, 8'hFF, 1, 1, 4, 8'h11));

        // Five-line edge-mode vectors: index stays within 0..4.
        vt_5.push_back(mk(8'h10, 8'h1F, 1, 0, 0, 8'h10));
        vt_5.push_back(mk(8'h10, 8'h1F, 1, 1, 4, 8'h10));
        vt_5.push_back(mk(8'h10, 8'h1F, 1, 0, 0, 8'h00));
        vt_5.push_back(mk(8'h18, 8'h1F, 1, 0, 0, 8'h08));
        vt_5.push_back(mk(8'h18, 8'h1F, 1, 1, 3, 8'h08));
        vt_5.push_back(mk(8'h00, 8'h1F, 1, 0, 0, 8'h00));
        vt_5.push_back(mk(8'h1F, 8'h0F, 1, 0, 0, 8'h1F));
        vt_5.push_back(mk(8'h1F, 8'h0F, 1, 1, 3, 8'h1F));
        vt_5.push_back(mk(8'h1F, 8'h0F, 1, 1, 2, 8'h17));

        rst_n = 1'b0;
        req_e = '0; mask_e = 8'hFF; rdy_e = 1'b0;
        req_l = '0; mask_l = 8'hFF; rdy_l = 1'b0;
        req_5 = '0; mask_5 = 5'h1F; rdy_5 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 10; i++) drive_cycle(0, 100 + i, mk(8'h00, 8'hFF, 0, 0, 0, 8'h00));

        for (int i = 0; i < vt_e.size(); i++) drive_cycle(0, i, vt_e[i]);
        for (int i = 0; i < vt_5.size(); i++) drive_cycle(2, i, vt_5[i]);

        // Leave a stalled handshake open on the edge unit while the level unit runs.
        @(negedge clk);
        req_e = 8'h80; rdy_e = 1'b0;
        for (int i = 0; i < vt_l.size(); i++) drive_cycle(1, i, vt_l[i]);
        check("edge8 stalled before reset out_valid", 64'(ov_e), 64'd1);
        check("edge8 stalled before reset out_idx",   64'(oi_e), 64'd7);

        // Asynchronous reset mid-stream: outputs clear without a clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset level8 out_valid", 64'(ov_l),   64'd0);
        check("reset level8 out_idx",   64'(oi_l),   64'd0);
        check("reset level8 pending",   64'(pend_l), 64'd0);
        check("reset edge8 out_valid",  64'(ov_e),   64'd0);
        check("reset edge8 pending",    64'(pend_e), 64'd0);
        req_e = '0; req_l = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Lost acknowledge: the request has to rise again to be presented.
        drive_cycle(0, 200, mk(8'h80, 8'hFF, 0, 0, 0, 8'h80));
        drive_cycle(0, 201, mk(8'h80, 8'hFF, 0, 1, 7, 8'h80));
        drive_cycle(0, 202, mk(8'h80, 8'hFF, 1, 0, 0, 8'h00));

        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
